// File: rtl/vending_machine_multi_if.sv
// Request/response bundle between the key-input layer and the vending controller.
// The master drives the i_* fields; the controller (slave) drives the o_* fields.
interface vending_machine_multi_if #(
   parameter int MONEY_W = 5,
   parameter int SEL_W   = 2
);
   logic [SEL_W-1:0]   i_sel;
   logic [MONEY_W-1:0] i_price;
   logic               i_coin_valid;
   logic [MONEY_W-1:0] i_coin;
   logic               i_confirm;
   logic               i_cancel;
   logic               i_restock;
   logic [MONEY_W-1:0] o_money;
   logic [MONEY_W-1:0] o_price;
   logic [MONEY_W-1:0] o_change;
   logic               o_change_pulse;
   logic               o_goods;
   logic [SEL_W-1:0]   o_goods_sel;
   logic               o_ready;
   logic               o_empty;
   logic               o_coin_reject;

   modport master (
      output i_sel, i_price, i_coin_valid, i_coin, i_confirm, i_cancel, i_restock,
      input  o_money, o_price, o_change, o_change_pulse, o_goods, o_goods_sel,
             o_ready, o_empty, o_coin_reject
   );
   modport slave (
      input  i_sel, i_price, i_coin_valid, i_coin, i_confirm, i_cancel, i_restock,
      output o_money, o_price, o_change, o_change_pulse, o_goods, o_goods_sel,
             o_ready, o_empty, o_coin_reject
   );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-channel vending controller: credit collection, per-channel stock,
// inactivity auto-refund and serial change dispensing (one unit per cycle).
module vending_machine_multi #(
   parameter int MONEY_W    = 5,
   parameter int N_GOODS    = 4,
   parameter int SEL_W      = 2,
   parameter int STOCK_W    = 4,
   parameter int INIT_STOCK = 5,
   parameter int TIMEOUT    = 10000
) (
   input  logic                   clk,
   input  logic                   reset,
   vending_machine_multi_if.slave bus
);
   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

   state_t             r_state, w_state_nx;
   logic [MONEY_W-1:0] r_money, w_money_nx;
   logic [MONEY_W-1:0] r_price, w_price_nx;
   logic [MONEY_W-1:0] r_change, w_change_nx;
   logic [SEL_W-1:0]   r_sel, w_sel_nx;
   logic [SEL_W-1:0]   r_goods_sel, w_goods_sel_nx;
   logic               r_goods, w_goods_nx;
   logic               r_pulse, w_pulse_nx;
   logic               r_reject, w_reject_nx;
   logic [TO_W-1:0]    r_to_cnt, w_to_cnt_nx;
   logic               r_to_half, w_to_half_nx;
   logic [STOCK_W-1:0] r_stock [N_GOODS];
   logic               w_restock, w_take;

   logic [MONEY_W:0]   w_sum;
   logic               w_coin_ok, w_active, w_timeout;
   logic [MONEY_W-1:0] w_credit;
   logic [STOCK_W-1:0] w_sel_stock;

   // Coin is accepted first; cancel/confirm then see the updated credit.
   assign w_sum       = {1'b0, r_money} + {1'b0, bus.i_coin};
   assign w_coin_ok   = bus.i_coin_valid && !w_sum[MONEY_W];
   assign w_credit    = w_coin_ok ? w_sum[MONEY_W-1:0] : r_money;
   assign w_active    = bus.i_coin_valid || bus.i_confirm || bus.i_cancel;
   assign w_timeout   = !w_active && (r_to_cnt == TO_W'(TIMEOUT));
   assign w_sel_stock = r_stock[r_sel];

   always_comb begin
      w_state_nx     = r_state;
      w_money_nx     = r_money;
      w_price_nx     = r_price;
      w_change_nx    = r_change;
      w_sel_nx       = r_sel;
      w_goods_sel_nx = r_goods_sel;
      w_to_cnt_nx    = r_to_cnt;
      w_to_half_nx   = r_to_half;
      w_goods_nx     = 1'b0;
      w_pulse_nx     = 1'b0;
      w_reject_nx    = 1'b0;
      w_restock      = 1'b0;
      w_take         = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_restock = bus.i_restock;
            if (bus.i_coin_valid && bus.i_coin != '0) begin
               w_sel_nx     = bus.i_sel;
               w_price_nx   = bus.i_price;
               w_money_nx   = bus.i_coin;
               w_to_cnt_nx  = '0;
               w_to_half_nx = 1'b0;
               w_state_nx   = S_COLLECT;
            end
         end
         S_COLLECT: begin
            w_money_nx  = w_credit;
            w_reject_nx = bus.i_coin_valid && !w_coin_ok;
            // Half-rate counter: one tick per two idle cycles.
            if (w_active) begin
               w_to_cnt_nx  = '0;
               w_to_half_nx = 1'b0;
            end else if (!w_timeout) begin
               w_to_half_nx = ~r_to_half;
               if (r_to_half) w_to_cnt_nx = r_to_cnt + TO_W'(1);
            end
            if (bus.i_cancel || w_timeout) begin
               w_change_nx = w_credit;
               w_money_nx  = '0;
               if (w_credit != '0) begin
                  w_state_nx = S_CHANGE;
                  w_pulse_nx = 1'b1;
               end else begin
                  w_state_nx = S_IDLE;
               end
            end else if (bus.i_confirm && w_credit >= r_price && w_sel_stock != '0) begin
               w_state_nx     = S_VEND;
               w_goods_nx     = 1'b1;
               w_goods_sel_nx = r_sel;
               w_take         = 1'b1;
               w_change_nx    = w_credit - r_price;
               w_money_nx     = '0;
            end
         end
         S_VEND: begin
            w_reject_nx = bus.i_coin_valid;
            if (r_change != '0) begin
               w_state_nx = S_CHANGE;
               w_pulse_nx = 1'b1;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_CHANGE: begin
            w_reject_nx = bus.i_coin_valid;
            if (r_change <= MONEY_W'(1)) begin
               w_change_nx = '0;
               w_state_nx  = S_IDLE;
            end else begin
               w_change_nx = r_change - MONEY_W'(1);
               w_pulse_nx  = 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_money     <= '0;
         r_price     <= '0;
         r_change    <= '0;
         r_sel       <= '0;
         r_goods_sel <= '0;
         r_goods     <= 1'b0;
         r_pulse     <= 1'b0;
         r_reject    <= 1'b0;
         r_to_cnt    <= '0;
         r_to_half   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_money     <= w_money_nx;
         r_price     <= w_price_nx;
         r_change    <= w_change_nx;
         r_sel       <= w_sel_nx;
         r_goods_sel <= w_goods_sel_nx;
         r_goods     <= w_goods_nx;
         r_pulse     <= w_pulse_nx;
         r_reject    <= w_reject_nx;
         r_to_cnt    <= w_to_cnt_nx;
         r_to_half   <= w_to_half_nx;
      end
   end

   // Restock (IDLE only) and vend decrement (COLLECT->VEND) never coincide.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int g = 0; g < N_GOODS; g++) r_stock[g] <= STOCK_W'(INIT_STOCK);
      end else if (w_restock && int'(bus.i_sel) < N_GOODS) begin
         r_stock[bus.i_sel] <= STOCK_W'(INIT_STOCK);
      end else if (w_take && w_sel_stock != '0) begin
         r_stock[r_sel] <= w_sel_stock - STOCK_W'(1);
      end
   end

   assign bus.o_money        = r_money;
   assign bus.o_price        = r_price;
   assign bus.o_change       = r_change;
   assign bus.o_change_pulse = r_pulse;
   assign bus.o_goods        = r_goods;
   assign bus.o_goods_sel    = r_goods_sel;
   assign bus.o_coin_reject  = r_reject;
   assign bus.o_ready        = (r_state == S_IDLE);
   assign bus.o_empty        = (int'(bus.i_sel) < N_GOODS) ? (r_stock[bus.i_sel] == '0) : 1'b1;
endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: reference-model scoreboard on every cycle,
// a vector table for the basic purchase, directed corner sequences, then random traffic.
module tb_vending_machine_multi;
   localparam int MW = 5, NG = 4, SW = 2, SKW = 4, INIT = 5, TO = 20;
   localparam int MAXV = 31;
   localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_CHANGE = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;

   vending_machine_multi_if #(.MONEY_W(MW), .SEL_W(SW)) bus ();

   vending_machine_multi #(
      .MONEY_W(MW), .N_GOODS(NG), .SEL_W(SW), .STOCK_W(SKW),
      .INIT_STOCK(INIT), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0] sel;
      logic [MW-1:0] price;
      logic          cv;
      logic [MW-1:0] coin;
      logic          cf, cn, rs;
   } in_t;

   typedef struct {
      in_t in;
      int  money, change, goods, gsel, pulse, ready;
   } vec_t;

   // reference model: transaction-level bookkeeping
   int m_mode, m_money, m_price, m_change, m_sel, m_gsel, m_idle;
   int m_goods, m_pulse, m_rej;
   int m_stock[NG];

   function automatic in_t mk(int sel, int price, int cv, int coin, int cf, int cn, int rs);
      in_t v;
      v.sel = SW'(sel); v.price = MW'(price); v.cv = cv[0]; v.coin = MW'(coin);
      v.cf = cf[0]; v.cn = cn[0]; v.rs = rs[0];
      return v;
   endfunction

   function automatic in_t idle(int sel);
      return mk(sel, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic vec_t mkv(in_t v, int money, int change, int goods, int gsel, int pulse, int ready);
      vec_t r;
      r.in = v; r.money = money; r.change = change; r.goods = goods;
      r.gsel = gsel; r.pulse = pulse; r.ready = ready;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_money = 0; m_price = 0; m_change = 0; m_sel = 0; m_gsel = 0;
      m_idle = 0; m_goods = 0; m_pulse = 0; m_rej = 0;
      for (int g = 0; g < NG; g++) m_stock[g] = INIT;
   endtask

   task automatic model_step(input in_t v);
      bit act, quit;
      m_goods = 0; m_rej = 0;
      case (m_mode)
         M_IDLE: begin
            if (v.rs) m_stock[v.sel] = INIT;
            if (v.cv && v.coin != 0) begin
               m_sel = int'(v.sel); m_price = int'(v.price); m_money = int'(v.coin);
               m_idle = 0; m_mode = M_COLLECT;
            end
         end
         M_COLLECT: begin
            act = v.cv || v.cf || v.cn;
            if (v.cv) begin
               if (m_money + int'(v.coin) <= MAXV) m_money += int'(v.coin);
               else m_rej = 1;
            end
            // idle timer ticks every second cycle, so TIMEOUT ticks == 2*TIMEOUT idle cycles
            quit = v.cn || (!act && m_idle == 2 * TO);
            if (act) m_idle = 0; else m_idle++;
            if (quit) begin
               m_change = m_money; m_money = 0;
               m_mode = (m_change != 0) ? M_CHANGE : M_IDLE;
            end else if (v.cf && m_money >= m_price && m_stock[m_sel] > 0) begin
               m_goods = 1; m_gsel = m_sel; m_stock[m_sel]--;
               m_change = m_money - m_price; m_money = 0; m_mode = M_VEND;
            end
         end
         M_VEND: begin
            m_rej = int'(v.cv);
            m_mode = (m_change != 0) ? M_CHANGE : M_IDLE;
         end
         default: begin
            m_rej = int'(v.cv);
            m_change--;
            if (m_change == 0) m_mode = M_IDLE;
         end
      endcase
      m_pulse = (m_mode == M_CHANGE) ? 1 : 0;
   endtask

   task automatic check_model();
      chk("money", int'(bus.o_money), m_money);
      chk("price", int'(bus.o_price), m_price);
      chk("change", int'(bus.o_change), m_change);
      chk("change_pulse", int'(bus.o_change_pulse), m_pulse);
      chk("goods", int'(bus.o_goods), m_goods);
      if (m_goods != 0) chk("goods_sel", int'(bus.o_goods_sel), m_gsel);
      chk("coin_reject", int'(bus.o_coin_reject), m_rej);
      chk("ready", int'(bus.o_ready), (m_mode == M_IDLE) ? 1 : 0);
      chk("empty", int'(bus.o_empty), (m_stock[int'(bus.i_sel)] == 0) ? 1 : 0);
   endtask

   task automatic drive(input in_t v);
      bus.i_sel = v.sel; bus.i_price = v.price; bus.i_coin_valid = v.cv;
      bus.i_coin = v.coin; bus.i_confirm = v.cf; bus.i_cancel = v.cn; bus.i_restock = v.rs;
   endtask

   task automatic step(input in_t v);
      drive(v);
      model_step(v);
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   // Run idle cycles until the controller is back in IDLE, counting change pulses.
   task automatic drain(input int sel, input int already, output int total);
      total = already;
      for (int i = 0; i < 40 && !bus.o_ready; i++) begin
         step(idle(sel));
         if (bus.o_change_pulse) total++;
      end
      chk("drain_done", int'(bus.o_ready), 1);
   endtask

   vec_t tbl[7];
   int   tot, rej_cnt, waited;

   initial begin
      drive(idle(0));
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_model();
      reset = 1'b1;

      // basic purchase: sel 1, price 7, coins 5+5, change 3
      tbl[0] = mkv(mk(1, 7, 1, 5, 0, 0, 0), 5, 0, 0, 0, 0, 0);
      tbl[1] = mkv(mk(1, 7, 1, 5, 0, 0, 0), 10, 0, 0, 0, 0, 0);
      tbl[2] = mkv(mk(1, 7, 0, 0, 1, 0, 0), 0, 3, 1, 1, 0, 0);
      tbl[3] = mkv(idle(1), 0, 3, 0, 0, 1, 0);
      tbl[4] = mkv(idle(1), 0, 2, 0, 0, 1, 0);
      tbl[5] = mkv(idle(1), 0, 1, 0, 0, 1, 0);
      tbl[6] = mkv(idle(1), 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].in);
         chk($sformatf("tbl%0d_money", i), int'(bus.o_money), tbl[i].money);
         chk($sformatf("tbl%0d_change", i), int'(bus.o_change), tbl[i].change);
         chk($sformatf("tbl%0d_goods", i), int'(bus.o_goods), tbl[i].goods);
         if (tbl[i].goods != 0) chk($sformatf("tbl%0d_gsel", i), int'(bus.o_goods_sel), tbl[i].gsel);
         chk($sformatf("tbl%0d_pulse", i), int'(bus.o_change_pulse), tbl[i].pulse);
         chk($sformatf("tbl%0d_ready", i), int'(bus.o_ready), tbl[i].ready);
      end

      // zero coin in IDLE ignored; overflow reject at credit 28; exact-price vend
      step(mk(0, 28, 1, 0, 0, 0, 0));
      chk("zero_coin_ready", int'(bus.o_ready), 1);
      chk("zero_coin_noreject", int'(bus.o_coin_reject), 0);
      step(mk(0, 28, 1, 10, 0, 0, 0));
      step(mk(0, 28, 1, 10, 0, 0, 0));
      step(mk(0, 28, 1, 8, 0, 0, 0));
      step(mk(0, 28, 1, 5, 0, 0, 0));
      chk("ovf_reject", int'(bus.o_coin_reject), 1);
      chk("ovf_money", int'(bus.o_money), 28);
      step(mk(0, 28, 0, 0, 1, 0, 0));
      chk("exact_goods", int'(bus.o_goods), 1);
      chk("exact_change", int'(bus.o_change), 0);
      step(idle(0));
      chk("exact_idle", int'(bus.o_ready), 1);
      chk("exact_nopulse", int'(bus.o_change_pulse), 0);

      // drain channel 2, refused confirm on empty stock, cancel, restock
      for (int k = 0; k < INIT; k++) begin
         step(mk(2, 3, 1, 3, 0, 0, 0));
         step(mk(2, 3, 0, 0, 1, 0, 0));
         chk("drain2_goods", int'(bus.o_goods), 1);
         step(idle(2));
      end
      chk("ch2_empty", int'(bus.o_empty), 1);
      step(mk(2, 3, 1, 10, 0, 0, 0));
      step(mk(2, 3, 0, 0, 1, 0, 0));
      chk("empty_novend", int'(bus.o_goods), 0);
      chk("empty_money", int'(bus.o_money), 10);
      step(mk(2, 3, 0, 0, 0, 1, 0));
      drain(2, int'(bus.o_change_pulse), tot);
      chk("cancel10_pulses", tot, 10);
      step(mk(2, 0, 0, 0, 0, 0, 1));
      chk("restock_not_empty", int'(bus.o_empty), 0);

      // inactivity auto-refund
      step(mk(0, 9, 1, 4, 0, 0, 0));
      waited = 0;
      for (int i = 0; i < 2 * TO + 10 && !bus.o_change_pulse; i++) begin
         step(idle(0));
         waited++;
      end
      chk("timeout_cycles", waited, 2 * TO + 1);
      drain(0, int'(bus.o_change_pulse), tot);
      chk("timeout_pulses", tot, 4);
      chk("timeout_money", int'(bus.o_money), 0);

      // confirm+cancel together: cancel wins; coin during CHANGE refused
      step(mk(0, 6, 1, 9, 0, 0, 0));
      step(mk(0, 6, 0, 0, 1, 1, 0));
      chk("cc_nogoods", int'(bus.o_goods), 0);
      chk("cc_change", int'(bus.o_change), 9);
      tot = int'(bus.o_change_pulse);
      rej_cnt = 0;
      for (int i = 0; i < 40 && !bus.o_ready; i++) begin
         step((i == 2) ? mk(0, 0, 1, 3, 0, 0, 0) : idle(0));
         if (bus.o_change_pulse) tot++;
         if (bus.o_coin_reject) rej_cnt++;
      end
      chk("cc_pulses", tot, 9);
      chk("cc_rejects", rej_cnt, 1);

      // empty channel 3, then reset mid-CHANGE restores everything
      for (int k = 0; k < INIT; k++) begin
         step(mk(3, 1, 1, 1, 0, 0, 0));
         step(mk(3, 1, 0, 0, 1, 0, 0));
         step(idle(3));
      end
      chk("ch3_empty", int'(bus.o_empty), 1);
      step(mk(3, 9, 1, 5, 0, 0, 0));
      step(mk(3, 9, 0, 0, 0, 1, 0));
      chk("pre_reset_change", int'(bus.o_change), 5);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_model();
      chk("reset_ch3_stock", int'(bus.o_empty), 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      check_model();

      // randomized traffic, alternating busy and quiet stretches
      for (int blk = 0; blk < 15; blk++) begin
         for (int c = 0; c < 200; c++) begin
            in_t v;
            bit  quiet;
            quiet = (blk % 3 == 2);
            v.sel   = SW'($urandom_range(0, NG - 1));
            v.price = MW'($urandom_range(1, 20));
            v.coin  = MW'($urandom_range(1, 15));
            v.cv    = ($urandom_range(0, 99) < (quiet ? 2 : 35));
            v.cf    = ($urandom_range(0, 99) < (quiet ? 1 : 15));
            v.cn    = ($urandom_range(0, 99) < (quiet ? 0 : 4));
            v.rs    = ($urandom_range(0, 99) < (quiet ? 2 : 5));
            step(v);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
